// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forward-select encodings and register address width
package hazard_pkg;
   localparam int         REG_ADDR_W = 5;
   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_WB     = 2'b01;
   localparam logic [1:0] FWD_MEM    = 2'b10;
endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: operand forward select for one Execute-stage source register
//   rs                      source register being read in Execute
//   rd_m, reg_write_m       Memory-stage destination and write enable
//   rd_w, reg_write_w       Writeback-stage destination and write enable
//   sel                     FWD_MEM / FWD_WB / FWD_RF
module fwd_sel_unit
   import hazard_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic                  reg_write_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  reg_write_w,
   output logic [1:0]            sel
);
   // Memory is checked first so the youngest producer wins; x0 never forwards
   always_comb
      sel = (reg_write_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
            (reg_write_w && rd_w != '0 && rd_w == rs) ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline forwarding, load-use stall and branch flush control
//   clk, reset_n                      clock, async active-low reset
//   rs1_d, rs2_d                      Decode-stage sources
//   rs1_e, rs2_e, rd_e                Execute-stage sources and destination
//   reg_write_e, load_e, pc_src_e     Execute-stage write, load, taken branch
//   forward_a_e, forward_b_e          operand-mux selects
//   stall_f, stall_d, flush_d, flush_e pipeline register controls
//   stall_cnt, flush_cnt              saturating event counters
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rs1_e,
   input  logic [REG_ADDR_W-1:0] rs2_e,
   input  logic [REG_ADDR_W-1:0] rd_e,
   input  logic                  reg_write_e,
   input  logic                  load_e,
   input  logic                  pc_src_e,
   output logic [1:0]            forward_a_e,
   output logic [1:0]            forward_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic [15:0]           stall_cnt,
   output logic [15:0]           flush_cnt
);
   logic [REG_ADDR_W-1:0] rd_m, rd_w;
   logic                  reg_write_m, reg_write_w;
   logic                  lw_stall;

   fwd_sel_unit u_fwd_a (
      .rs(rs1_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .sel(forward_a_e)
   );

   fwd_sel_unit u_fwd_b (
      .rs(rs2_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .sel(forward_b_e)
   );

   // A taken branch squashes the Decode instruction, so no stall is needed for it
   always_comb begin
      lw_stall = load_e && rd_e != '0 && !pc_src_e && (rd_e == rs1_d || rd_e == rs2_d);
      stall_f  = lw_stall;
      stall_d  = lw_stall;
      flush_d  = pc_src_e;
      flush_e  = lw_stall || pc_src_e;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rd_m        <= '0;
         reg_write_m <= 1'b0;
         rd_w        <= '0;
         reg_write_w <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         rd_m        <= rd_e;
         reg_write_m <= reg_write_e;
         rd_w        <= rd_m;
         reg_write_w <= reg_write_m;
         if (lw_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
         if (pc_src_e && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table-driven bench for hazard_ctrl
module tb_hazard_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
   logic        reg_write_e, load_e, pc_src_e;
   logic [1:0]  forward_a_e, forward_b_e;
   logic        stall_f, stall_d, flush_d, flush_e;
   logic [15:0] stall_cnt, flush_cnt;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic        rw, ld, pc;
      logic [1:0]  fa, fb;
      logic        st, fd, fe;
      logic [15:0] sc, fc;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .reg_write_e(reg_write_e), .load_e(load_e), .pc_src_e(pc_src_e),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int a, b, c, d, e, f, g, h);
      rs1_d = 5'(a); rs2_d = 5'(b); rs1_e = 5'(c); rs2_e = 5'(d); rd_e = 5'(e);
      reg_write_e = 1'(f); load_e = 1'(g); pc_src_e = 1'(h);
   endtask

   task automatic add(input int a, b, c, d, e, f, g, h, i, j, k, l, m, n, o);
      vec_t v;
      v.rs1_d = 5'(a); v.rs2_d = 5'(b); v.rs1_e = 5'(c); v.rs2_e = 5'(d); v.rd_e = 5'(e);
      v.rw = 1'(f); v.ld = 1'(g); v.pc = 1'(h);
      v.fa = 2'(i); v.fb = 2'(j); v.st = 1'(k); v.fd = 1'(l); v.fe = 1'(m);
      v.sc = 16'(n); v.fc = 16'(o);
      vq.push_back(v);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " fwd_a"}, 32'(forward_a_e), 0);
      chk({tag, " fwd_b"}, 32'(forward_b_e), 0);
      chk({tag, " stalls/flushes"}, {28'd0, stall_f, stall_d, flush_d, flush_e}, 0);
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 0);
      chk({tag, " flush_cnt"}, 32'(flush_cnt), 0);
   endtask

   initial begin
      //   rs1_d rs2_d rs1_e rs2_e rd_e rw ld pc | fa fb st fd fe sc fc
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 5, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0);
      add(0, 0, 5, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
      add(0, 0, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 9, 9, 1, 0, 0,   0, 2, 0, 0, 0, 0, 0);
      add(0, 0, 9, 9, 3, 1, 0, 0,   2, 2, 0, 0, 0, 0, 0);
      add(0, 0, 9, 3, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0);
      add(0, 0, 3, 9, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 4, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 4, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 4, 4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      add(0, 7, 0, 0, 7, 1, 1, 0,   0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 7, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1, 0);
      add(7, 0, 0, 0, 7, 1, 1, 0,   0, 0, 1, 0, 1, 1, 0);
      add(0, 7, 0, 0, 7, 1, 1, 1,   0, 0, 0, 1, 1, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1);
      add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 2, 1);
      add(0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 2, 2);
      add(0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 2, 2);
      add(0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 2, 2);
      add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 2);
      add(7, 5, 0, 0, 6, 1, 1, 0,   0, 0, 0, 0, 0, 2, 2);
      add(0, 0, 0, 6, 0, 0, 0, 0,   0, 2, 0, 0, 0, 2, 2);
      add(0, 0, 0, 6, 0, 0, 0, 0,   0, 1, 0, 0, 0, 2, 2);

      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 chk_all_zero("in reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vq[i]) begin
         drive(vq[i].rs1_d, vq[i].rs2_d, vq[i].rs1_e, vq[i].rs2_e, vq[i].rd_e,
               vq[i].rw, vq[i].ld, vq[i].pc);
         @(negedge clk);
         chk($sformatf("v%0d fwd_a", i), 32'(forward_a_e), 32'(vq[i].fa));
         chk($sformatf("v%0d fwd_b", i), 32'(forward_b_e), 32'(vq[i].fb));
         chk($sformatf("v%0d stall_f", i), 32'(stall_f), 32'(vq[i].st));
         chk($sformatf("v%0d stall_d", i), 32'(stall_d), 32'(vq[i].st));
         chk($sformatf("v%0d flush_d", i), 32'(flush_d), 32'(vq[i].fd));
         chk($sformatf("v%0d flush_e", i), 32'(flush_e), 32'(vq[i].fe));
         chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vq[i].sc));
         chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(vq[i].fc));
         @(posedge clk);
         #1;
      end

      // Async reset in the middle of a stall with forwarding history pending
      drive(5, 0, 0, 0, 5, 1, 1, 0);
      @(negedge clk);
      chk("pre-reset stall", 32'(stall_f), 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async clr stall_cnt", 32'(stall_cnt), 0);
      chk("async clr flush_cnt", 32'(flush_cnt), 0);
      drive(0, 0, 5, 5, 0, 0, 0, 0);
      #1;
      chk("reset fwd_a", 32'(forward_a_e), 0);
      chk("reset fwd_b", 32'(forward_b_e), 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post-reset fwd_a", 32'(forward_a_e), 0);
      chk("post-reset fwd_b", 32'(forward_b_e), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk_all_zero("post-reset idle");

      // Hold a load-use hazard long enough to saturate stall_cnt
      @(posedge clk);
      #1 drive(0, 7, 0, 0, 7, 1, 1, 0);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      chk("stall_cnt near sat", 32'(stall_cnt), 32'hFFFE);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("stall_cnt sat", 32'(stall_cnt), 32'hFFFF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stall_cnt held", 32'(stall_cnt), 32'hFFFF);
      chk("flush_cnt idle", 32'(flush_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
